slot_dispatch_decoder: RTL
==========================

Name: slot_dispatch_decoder

Overview:
- Inverse of the priority encoder: takes a registered index request (e.g. encoder output gated by a one-pulse strobe) and decodes it to a one-cycle one-hot grant.
- Each slot has a cooldown timer that blocks re-grant until it expires, for game-side spawn/deploy slots.
- Cooldown decrements only on a `tick` enable (from a clock-divider output), so the block runs on the single system clock.

Parameters:
- N_SLOT, 8, number of slots (1..2**IDX_W).
- IDX_W, 3, request index width.
- CD_W, 16, cooldown counter width.
- COOLDOWN, 1000, ticks loaded into a slot's counter on grant (0 = slot never busy; must be < 2**CD_W).

Ports:
- clk  in  1  system clock, all state on posedge.
- rst_n  in  1  asynchronous active-low reset.
- tick  in  1  cooldown decrement enable, one-cycle pulse.
- clear  in  1  synchronous flush of all cooldowns (and pending entry).
- req_valid  in  1  request strobe, one cycle per request.
- req_idx  in  IDX_W  requested slot index.
- slot_en  in  N_SLOT  per-slot enable mask; 0 = slot locked.
- grant_onehot  out  N_SLOT  one-hot grant pulse, registered.
- grant_valid  out  1  high the cycle grant_onehot is non-zero.
- grant_idx  out  IDX_W  index of current grant (0 when no grant).
- reject  out  1  one-cycle pulse: request dropped.
- busy  out  N_SLOT  bit i = cooldown counter i non-zero.

Behaviour:
- Reset (async, rst_n=0): all counters 0, grant_onehot/grant_valid/grant_idx/reject = 0, busy = 0, pending empty.
- Accept condition at cycle T: req_valid & req_idx<N_SLOT & slot_en[req_idx] & cd[req_idx]==0 & clear==0.
  - Accepted: at T+1 grant_onehot = 1<<req_idx, grant_valid=1, grant_idx=req_idx. Counter loads COOLDOWN at the T edge, so busy[idx] is high from T+1 when COOLDOWN>0.
  - Not accepted (out of range, masked, busy, or clear): reject=1 at T+1, no grant. Busy-slot case is modified by the optional feature.
- Outputs are one-cycle pulses; with no new accept/reject they return to 0 the next cycle.
- Counter update per slot, priority high to low:
  - clear -> 0.
  - grant load -> COOLDOWN.
  - tick & cd!=0 -> cd-1.
  - Otherwise hold.
  - Load on the same cycle as tick: the load wins, no decrement.
  - Counters saturate at 0; never wrap.
- COOLDOWN=0: a slot can be granted on consecutive cycles; busy stays 0.
- busy is combinational from the counter registers only (no input path).
- At most one grant per cycle.
- clear and req_valid in the same cycle: reject=1, counters zeroed.
- Reset mid-cooldown: counters zeroed immediately; any in-flight grant/reject pulse is squashed.

Optional Feature:
- Macro: SLOT_DISPATCH_PENDING_EN.
- Without it: a request to a busy, enabled, in-range slot is rejected.
- With it: a one-entry pending register (valid + idx) is added.
  - Busy-slot request with pending empty: stored, no reject pulse.
  - Busy-slot request with pending full: rejected.
  - The pending entry issues a grant in the first cycle its slot's counter is 0 and slot_en is set. It has priority over any new req_valid that cycle; that new request is rejected.
  - If the slot is masked when its counter reaches 0, the entry is dropped with a reject pulse.
  - clear empties pending without a reject pulse.

Decomposition:
- Package slot_dispatch_pkg: N_SLOT, IDX_W, CD_W defaults; onehot(idx) function; pending-entry struct {valid, idx}.
- Sub-module slot_cd_ctr: one counter with load/clear/tick and busy out, instantiated N_SLOT times by generate. The top holds the accept logic, the pending register and the output registers.

Test Plan:
- Reset then req_valid, req_idx=5, COOLDOWN=4 -> next cycle grant_onehot=8'b0010_0000, grant_idx=5, busy[5]=1; after 4 ticks busy[5]=0.
- Re-request idx 5 after 2 ticks (macro off) -> reject=1, no grant. Same with macro on -> no reject; grant for idx 5 in the cycle after the 4th tick.
- slot_en=8'hFB, request idx 2 -> reject=1, busy unchanged. With N_SLOT=6, request idx 7 -> reject=1.
- Grant idx 1 in the same cycle as tick -> cd[1]=COOLDOWN, not COOLDOWN-1. Assert clear mid-cooldown -> busy=0 next cycle; request in the clear cycle -> reject.
- COOLDOWN=0, req idx 3 on two consecutive cycles -> two consecutive grants of 8'h08, busy always 0.
- Deassert rst_n asynchronously while busy=8'hFF with a grant pulse pending -> all outputs 0 before the next clk edge; operation resumes cleanly after release.

Source files
------------

// File: rtl/slot_dispatch_pkg.sv
// Shared defaults and helpers for the slot dispatch decoder.
// Index widths up to MAX_IDX_W bits are supported by the helpers below.
package slot_dispatch_pkg;

    localparam int DEF_N_SLOT = 8;
    localparam int DEF_IDX_W  = 3;
    localparam int DEF_CD_W   = 16;
    localparam int MAX_IDX_W  = 8;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } pend_t;

    function automatic logic [2**MAX_IDX_W-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/slot_dispatch_decoder_if.sv
// Request/grant bundle between a requester (master) and the slot dispatch decoder (slave).
interface slot_dispatch_decoder_if #(
    parameter int N_SLOT = slot_dispatch_pkg::DEF_N_SLOT,
    parameter int IDX_W  = slot_dispatch_pkg::DEF_IDX_W
);
    logic              tick;
    logic              clear;
    logic              req_valid;
    logic [IDX_W-1:0]  req_idx;
    logic [N_SLOT-1:0] slot_en;
    logic [N_SLOT-1:0] grant_onehot;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;
    logic              reject;
    logic [N_SLOT-1:0] busy;

    modport master (
        output tick, clear, req_valid, req_idx, slot_en,
        input  grant_onehot, grant_valid, grant_idx, reject, busy
    );

    modport slave (
        input  tick, clear, req_valid, req_idx, slot_en,
        output grant_onehot, grant_valid, grant_idx, reject, busy
    );
endinterface

// File: rtl/slot_cd_ctr.sv
// Per-slot cooldown down-counter: clear beats load beats tick; saturates at zero.
module slot_cd_ctr #(
    parameter int          CD_W     = 16,
    parameter int unsigned COOLDOWN = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    input  logic tick,
    output logic busy
);
    logic [CD_W-1:0] cd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd_q <= '0;
        end else if (clear) begin
            cd_q <= '0;
        end else if (load) begin
            cd_q <= CD_W'(COOLDOWN);
        end else if (tick && cd_q != '0) begin
            cd_q <= cd_q - CD_W'(1);
        end
    end

    assign busy = (cd_q != '0);
endmodule

// File: rtl/slot_dispatch_decoder.sv
// Index-to-one-hot grant decoder with per-slot cooldown timers.
// Optional one-entry pending register for busy slots: define SLOT_DISPATCH_PENDING_EN.
module slot_dispatch_decoder
    import slot_dispatch_pkg::*;
#(
    parameter int          N_SLOT   = DEF_N_SLOT,
    parameter int          IDX_W    = DEF_IDX_W,
    parameter int          CD_W     = DEF_CD_W,
    parameter int unsigned COOLDOWN = 1000
) (
    input logic              clk,
    input logic              rst_n,
    slot_dispatch_decoder_if.slave bus
);
    localparam int NP = 1 << IDX_W;

    logic [N_SLOT-1:0] busy_w;
    logic [N_SLOT-1:0] load_w;
    logic [NP-1:0]     en_pad;
    logic [NP-1:0]     busy_pad;
    logic              in_range;
    logic              new_ok;
    logic              grant_nxt;
    logic              reject_nxt;
    logic [IDX_W-1:0]  grant_idx_nxt;

    logic [N_SLOT-1:0] grant_onehot_q;
    logic              grant_valid_q;
    logic [IDX_W-1:0]  grant_idx_q;
    logic              reject_q;

    // Padding to 2**IDX_W lets out-of-range indices select a harmless zero bit.
    assign en_pad   = NP'(bus.slot_en);
    assign busy_pad = NP'(busy_w);
    assign in_range = int'(bus.req_idx) < N_SLOT;
    assign new_ok   = bus.req_valid & in_range & en_pad[bus.req_idx]
                    & ~busy_pad[bus.req_idx] & ~bus.clear;

`ifdef SLOT_DISPATCH_PENDING_EN
    pend_t            pend_q;
    logic [IDX_W-1:0] pend_idx;
    logic             pend_ready;
    logic             pend_fire;
    logic             pend_drop;
    logic             pend_store;

    assign pend_idx   = IDX_W'(pend_q.idx);
    assign pend_ready = pend_q.valid & ~busy_pad[pend_idx] & ~bus.clear;
    assign pend_fire  = pend_ready & en_pad[pend_idx];
    assign pend_drop  = pend_ready & ~en_pad[pend_idx];
    assign pend_store = bus.req_valid & in_range & en_pad[bus.req_idx]
                      & busy_pad[bus.req_idx] & ~bus.clear & ~pend_q.valid;

    // A resolving pending entry owns the cycle; any new request is turned away.
    assign grant_nxt     = pend_fire | (new_ok & ~pend_ready);
    assign grant_idx_nxt = pend_fire ? pend_idx : bus.req_idx;
    assign reject_nxt    = pend_drop
                         | (bus.req_valid & ~(new_ok & ~pend_ready) & ~pend_store);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else if (bus.clear || pend_ready) begin
            pend_q <= '0;
        end else if (pend_store) begin
            pend_q.valid <= 1'b1;
            pend_q.idx   <= MAX_IDX_W'(bus.req_idx);
        end
    end
`else
    assign grant_nxt     = new_ok;
    assign grant_idx_nxt = bus.req_idx;
    assign reject_nxt    = bus.req_valid & ~new_ok;
`endif

    assign load_w = grant_nxt ? N_SLOT'(onehot(MAX_IDX_W'(grant_idx_nxt))) : '0;

    for (genvar i = 0; i < N_SLOT; i++) begin : g_cd
        slot_cd_ctr #(
            .CD_W     (CD_W),
            .COOLDOWN (COOLDOWN)
        ) u_cd (
            .clk   (clk),
            .rst_n (rst_n),
            .clear (bus.clear),
            .load  (load_w[i]),
            .tick  (bus.tick),
            .busy  (busy_w[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_onehot_q <= '0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            reject_q       <= 1'b0;
        end else begin
            grant_onehot_q <= load_w;
            grant_valid_q  <= grant_nxt;
            grant_idx_q    <= grant_nxt ? grant_idx_nxt : '0;
            reject_q       <= reject_nxt;
        end
    end

    assign bus.grant_onehot = grant_onehot_q;
    assign bus.grant_valid  = grant_valid_q;
    assign bus.grant_idx    = grant_idx_q;
    assign bus.reject       = reject_q;
    assign bus.busy         = busy_w;
endmodule
